// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer for the EX/MEM stage: req/ack handshake, byte lanes, load extension.
// Optional MISALIGN_TRAP_EN traps misaligned halfword/word accesses instead of truncating the address.
module mem_access_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_en,
  input  logic             Mem_rw_mem,
  input  logic [2:0]       size_type_mem,
  input  logic [WIDTH-1:0] ALU_out,
  input  logic [WIDTH-1:0] Data_B_out,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [WIDTH-1:0] dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic             dmem_ack,
  input  logic [WIDTH-1:0] dmem_rdata,
  output logic [WIDTH-1:0] load_data,
  output logic             load_valid,
  output logic             stall,
  output logic             bus_err,
  output logic             misalign_err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BUSY  = 3'd1,
    S_DONE  = 3'd2,
    S_ABORT = 3'd3,
    S_TRAP  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_size;
  logic [1:0]       r_off;
  logic             r_req;
  logic             r_we;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [3:0]       r_be;
  logic [WIDTH-1:0] r_load_data;
  logic             r_load_valid;
  logic             r_bus_err;

  logic [1:0]       w_off;
  logic [3:0]       w_be;
  logic [WIDTH-1:0] w_wdata;
  logic             w_trap;
  logic             w_stall;
  logic [7:0]       w_lane8;
  logic [15:0]      w_lane16;
  logic [WIDTH-1:0] w_ext;

  // Request decode: lane offset (low bits forced for h/w), byte enables and replicated store data
  always_comb begin
    w_off   = 2'b00;
    w_be    = 4'b1111;
    w_wdata = Data_B_out;
    case (size_type_mem[1:0])
      2'b00: begin
        w_off   = ALU_out[1:0];
        w_be    = 4'b0001 << ALU_out[1:0];
        w_wdata = {(WIDTH/8){Data_B_out[7:0]}};
      end
      2'b01: begin
        w_off   = {ALU_out[1], 1'b0};
        w_be    = 4'b0011 << {ALU_out[1], 1'b0};
        w_wdata = {(WIDTH/16){Data_B_out[15:0]}};
      end
      default: begin
        w_off   = 2'b00;
        w_be    = 4'b1111;
        w_wdata = Data_B_out;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_misalign_err;

  // Misalignment detect: halfword on odd byte, word on any non-zero offset
  always_comb begin
    w_misalign = 1'b0;
    case (size_type_mem[1:0])
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = ALU_out[0];
      default: w_misalign = (ALU_out[1:0] != 2'b00);
    endcase
    w_trap = mem_en & w_misalign;
  end

  // Misalign pulse register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_misalign_err <= 1'b0;
    end else begin
      r_misalign_err <= (w_next == S_TRAP);
    end
  end
  assign misalign_err = r_misalign_err;
`else
  assign w_trap       = 1'b0;
  assign misalign_err = 1'b0;
`endif

  // Next-state logic and combinational pipeline stall
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = mem_en;
        if (mem_en) begin
          w_next = w_trap ? S_TRAP : S_BUSY;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (dmem_ack) begin
          w_next = S_DONE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_next = S_ABORT;
        end else begin
          w_next = S_BUSY;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ABORT: w_next = S_IDLE;
      S_TRAP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (reset) begin
      w_stall = 1'b0;
    end else begin
      w_stall = w_stall;
    end
  end

  // State register and BUSY-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_BUSY && w_next == S_BUSY) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Load lane select and extension from the latched size/offset
  always_comb begin
    w_lane8  = dmem_rdata[7:0];
    w_lane16 = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_off)
      2'b00:   w_lane8 = dmem_rdata[7:0];
      2'b01:   w_lane8 = dmem_rdata[15:8];
      2'b10:   w_lane8 = dmem_rdata[23:16];
      2'b11:   w_lane8 = dmem_rdata[31:24];
      default: w_lane8 = dmem_rdata[7:0];
    endcase
    case (r_size)
      3'b000:  w_ext = {{(WIDTH-8){w_lane8[7]}}, w_lane8};
      3'b100:  w_ext = {{(WIDTH-8){1'b0}}, w_lane8};
      3'b001:  w_ext = {{(WIDTH-16){w_lane16[15]}}, w_lane16};
      3'b101:  w_ext = {{(WIDTH-16){1'b0}}, w_lane16};
      default: w_ext = dmem_rdata;
    endcase
  end

  // Registered memory-side outputs, request latch and load result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= 4'b0000;
      r_size       <= 3'b000;
      r_off        <= 2'b00;
      r_load_data  <= '0;
      r_load_valid <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_req        <= (w_next == S_BUSY);
      r_load_valid <= (r_state == S_BUSY) && dmem_ack && !r_we;
      r_bus_err    <= (w_next == S_ABORT);
      if (r_state == S_IDLE && w_next == S_BUSY) begin
        r_we    <= Mem_rw_mem;
        r_addr  <= {ALU_out[WIDTH-1:2], 2'b00};
        r_wdata <= w_wdata;
        r_be    <= w_be;
        r_size  <= size_type_mem;
        r_off   <= w_off;
      end
      if (r_state == S_BUSY && dmem_ack && !r_we) begin
        r_load_data <= w_ext;
      end
    end
  end

  assign dmem_req   = r_req;
  assign dmem_we    = r_we;
  assign dmem_addr  = r_addr;
  assign dmem_wdata = r_wdata;
  assign dmem_be    = r_be;
  assign load_data  = r_load_data;
  assign load_valid = r_load_valid;
  assign bus_err    = r_bus_err;
  assign stall      = w_stall;

endmodule
